// File: rtl/ifu.sv
// ifu: PC register, four-way next-PC select, word-addressed instruction memory (backdoor-loaded).
// Latency: pc takes npc one cycle after PCWr; instruction is a zero-latency read of the word at pc.
// Backpressure: none; PCWr low holds pc, and therefore instruction, stable.

module ifu_im #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);

  // Loaded only through the hierarchical backdoor im.im.
  logic [31:0] im [DEPTH];

  assign rdata = im[addr];

endmodule

module ifu #(
  parameter logic [31:0] CODE_SEG_PC = 32'h0000_3000,
  parameter int          IM_DEPTH    = 1024,
  parameter string       IM_FILE     = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWr,
  input  logic [1:0]  NPCSel,
  input  logic [31:0] regPC,
  input  logic [31:0] StoredInstruction,
  output logic [31:0] pc,
  output logic [31:0] instruction
);

  localparam int AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;

  logic [31:0]   pc4;
  logic [31:0]   npc;
  logic [31:0]   br_off;
  logic [31:0]   pc_off;
  logic [AW-1:0] im_addr;
  logic          unused_si;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{StoredInstruction[15]}}, StoredInstruction[15:0], 2'b00};
  // Opcode bits are decoded elsewhere; only the immediate fields matter here.
  assign unused_si = ^StoredInstruction[31:26];

  always_comb begin
    npc = pc4;
    case (NPCSel)
      2'b00:   npc = pc4;
      2'b01:   npc = regPC;
      2'b10:   npc = {pc4[31:28], StoredInstruction[25:0], 2'b00};
      2'b11:   npc = pc4 + br_off;
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= CODE_SEG_PC;
    end else if (PCWr) begin
      pc <= npc;
    end
  end

  // PCs outside the code segment wrap modulo the memory depth.
  assign pc_off  = pc - CODE_SEG_PC;
  assign im_addr = AW'(pc_off >> 2);

  ifu_im #(
    .DEPTH (IM_DEPTH),
    .AW    (AW)
  ) im (
    .addr  (im_addr),
    .rdata (instruction)
  );

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a PC/memory model checked every cycle plus hand-computed pc/word expectations.
module tb_ifu;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWr;
  logic [1:0]  NPCSel;
  logic [31:0] regPC;
  logic [31:0] StoredInstruction;
  logic [31:0] pc;
  logic [31:0] instruction;

  ifu #(
    .CODE_SEG_PC (BASE),
    .IM_DEPTH    (DEPTH),
    .IM_FILE     ("code.txt")
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .PCWr              (PCWr),
    .NPCSel            (NPCSel),
    .regPC             (regPC),
    .StoredInstruction (StoredInstruction),
    .pc                (pc),
    .instruction       (instruction)
  );

  always #5 clk = ~clk;

  logic [31:0] img [DEPTH];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mpc;
  bit          mvalid = 1'b0;

  function automatic int widx(logic [31:0] p);
    logic [31:0] d;
    d = p - BASE;
    return int'(d / 32'd4) % DEPTH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Image: filler words tagged with their index, plus a jump chain and a branch chain.
  task automatic load_image;
    for (int i = 0; i < DEPTH; i++) img[i] = 32'hC0DE_0000 | 32'(i);
    img[32'h40] = 32'h0800_0C42;
    img[32'h42] = 32'h0800_0C45;
    img[32'h45] = 32'h0800_0C43;
    img[32'h43] = 32'h0800_0C43;
    img[32'h46] = 32'h1000_0003;
    img[32'h4A] = 32'h1000_0000;
    img[32'h4B] = 32'h1000_FFFB;
    img[32'h47] = 32'h1000_FFFF;
    for (int i = 0; i < DEPTH; i++) dut.im.im[i] = img[i];
  endtask

  // Reference model: next PC straight from the architectural rules.
  always @(posedge clk) begin
    logic [31:0] p4;
    int          off;
    if (!reset) begin
      mpc    = BASE;
      mvalid = 1'b1;
    end else if (mvalid && PCWr) begin
      p4 = mpc + 32'd4;
      case (NPCSel)
        2'd0: mpc = p4;
        2'd1: mpc = regPC;
        2'd2: mpc = {p4[31:28], StoredInstruction[25:0], 2'b00};
        default: begin
          off = int'($signed(StoredInstruction[15:0]));
          mpc = p4 + 32'(off * 4);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_pc", pc, mpc);
      chk("model_instr", instruction, img[widx(mpc)]);
    end
  end

  task automatic step(input string name, input logic [31:0] epc, input int eidx);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_pc"}, pc, epc);
    chk({name, "_instr"}, instruction, img[eidx]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] jpc [4];
    int          jix [4];
    logic [31:0] bpc [4];
    int          bix [4];
    jpc = '{32'h3108, 32'h3114, 32'h310C, 32'h310C};
    jix = '{32'h42, 32'h45, 32'h43, 32'h43};
    bpc = '{32'h3128, 32'h312C, 32'h311C, 32'h311C};
    bix = '{32'h4A, 32'h4B, 32'h47, 32'h47};

    reset = 1'b0; PCWr = 1'b0; NPCSel = 2'd0; regPC = '0; StoredInstruction = '0;
    load_image();

    // Reset and write enable
    step("reset", 32'h3000, 0);
    reset = 1'b1; PCWr = 1'b0;
    step("hold", 32'h3000, 0);
    PCWr = 1'b1;
    step("pcwr", 32'h3004, 1);

    // PC+4 from reset
    load_image();
    reset = 1'b0;
    step("reset2", 32'h3000, 0);
    reset = 1'b1; PCWr = 1'b1; NPCSel = 2'd0;
    step("inc1", 32'h3004, 1);
    step("inc2", 32'h3008, 2);
    step("inc3", 32'h300C, 3);

    // Register jump, then a held cycle
    load_image();
    NPCSel = 2'd1;
    regPC = 32'h3004; step("jr1", 32'h3004, 1);
    regPC = 32'h3010; step("jr2", 32'h3010, 4);
    regPC = 32'h3008; step("jr3", 32'h3008, 2);
    PCWr = 1'b0; regPC = 32'h3100;
    step("hold2", 32'h3008, 2);
    step("hold3", 32'h3008, 2);
    PCWr = 1'b1;

    // J-type chain with instruction fed back
    load_image();
    NPCSel = 2'd1; regPC = 32'h3100;
    step("jstart", 32'h3100, 32'h40);
    NPCSel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      StoredInstruction = instruction;
      step("jtype", jpc[k], jix[k]);
    end

    // Branch chain: +3, 0, -5, -1
    load_image();
    NPCSel = 2'd1; regPC = 32'h3118;
    step("bstart", 32'h3118, 32'h46);
    NPCSel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      StoredInstruction = instruction;
      step("branch", bpc[k], bix[k]);
    end

    // Reset with unknown controls, then address wrap cases
    load_image();
    reset = 1'b0; PCWr = 1'bx; NPCSel = 2'bxx; regPC = 'x;
    step("rst_x", 32'h3000, 0);
    reset = 1'b1; PCWr = 1'b1; NPCSel = 2'd1;
    regPC = 32'h4008;     step("wrap_hi", 32'h4008, 2);
    regPC = 32'h2FFC;     step("wrap_lo", 32'h2FFC, 1023);
    regPC = 32'h3005;     step("unalign", 32'h3005, 1);
    regPC = 32'hFFFF_FFFC; step("top", 32'hFFFF_FFFC, 1023);
    NPCSel = 2'd0;
    step("pc4wrap", 32'h0000_0000, 0);

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
